// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Bundle of the signals between the MEM stage, the EXE/MEM pipeline register
// and the external 16-bit SRAM.
//
// Signals:
//   mem_read_in   load request from the EXE/MEM register
//   mem_write_in  store request from the EXE/MEM register
//   alu_res_in    32-bit byte address computed by EXE
//   val_rm_in     32-bit store data
//   sram_dq_in    16-bit read data returned by the SRAM
//   ready         0 = freeze the pipeline this cycle, 1 = pipeline may advance
//   mem_result    last completed load word
//   sram_addr     18-bit SRAM half-word address
//   sram_dq_out   16-bit SRAM write data
//   sram_we_n     SRAM write strobe, active low
//
// Modports:
//   slave   the MEM stage itself
//   master  the surroundings (pipeline register plus SRAM)
// ---------------------------------------------------------------------------
interface mem_stage_if;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [31:0] alu_res_in;
    logic [31:0] val_rm_in;
    logic [15:0] sram_dq_in;
    logic        ready;
    logic [31:0] mem_result;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_we_n;

    modport slave (
        input  mem_read_in,
        input  mem_write_in,
        input  alu_res_in,
        input  val_rm_in,
        input  sram_dq_in,
        output ready,
        output mem_result,
        output sram_addr,
        output sram_dq_out,
        output sram_we_n
    );

    modport master (
        output mem_read_in,
        output mem_write_in,
        output alu_res_in,
        output val_rm_in,
        output sram_dq_in,
        input  ready,
        input  mem_result,
        input  sram_addr,
        input  sram_dq_out,
        input  sram_we_n
    );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// MEM pipeline stage driving a 16-bit external SRAM. A 32-bit access is split
// into a low half-word phase (LO) and a high half-word phase (HI), each held
// for WAIT_CYCLES+1 cycles. The pipeline is frozen (ready=0) from the cycle
// the request is seen until the end of HI, then released for one DONE cycle.
//
// Parameters:
//   BASE_ADDR    byte address subtracted from alu_res_in before mapping
//   WAIT_CYCLES  extra cycles each half-word phase is held
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-high reset
//   bus   mem_stage_if.slave (pipeline request side plus SRAM pins)
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave bus
);

    // The counter must hold 0..WAIT_CYCLES; keep at least one bit so the
    // WAIT_CYCLES=0 case still elaborates.
    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [16:0]   word;
    logic [31:0]   data;
    logic          is_write;

    logic [17:0]   addr_q;
    logic [15:0]   dq_q;
    logic          we_n_q;
    logic [31:0]   result_q;

    logic          request;
    logic [31:0]   offset;
    logic [16:0]   word_next;
    logic          phase_last;

    assign request    = bus.mem_read_in | bus.mem_write_in;
    assign offset     = bus.alu_res_in - 32'(BASE_ADDR);
    // Word index wraps modulo 2^17 so it always fits the 18-bit half-word bus.
    assign word_next  = 17'(offset >> 2);
    assign phase_last = (cnt == CW'(WAIT_CYCLES));

    // ready is the only output decoded from state: the freeze has to begin in
    // the very cycle the request shows up, before any register could react.
    assign bus.ready       = (state == DONE) || ((state == IDLE) && !request);
    assign bus.mem_result  = result_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = dq_q;
    assign bus.sram_we_n   = we_n_q;

    // SRAM pins are loaded on the edge that enters each phase, so they are
    // valid for every cycle of LO/HI and simply hold through DONE and IDLE.
    // Read halves are captured on the edge that ends each phase, i.e. after
    // the SRAM has seen a stable address for the whole phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            word     <= '0;
            data     <= '0;
            is_write <= 1'b0;
            addr_q   <= '0;
            dq_q     <= '0;
            we_n_q   <= 1'b1;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        is_write <= bus.mem_write_in;
                        word     <= word_next;
                        data     <= bus.val_rm_in;
                        cnt      <= '0;
                        addr_q   <= {word_next, 1'b0};
                        dq_q     <= bus.val_rm_in[15:0];
                        we_n_q   <= ~bus.mem_write_in;
                        state    <= LO;
                    end
                end
                LO: begin
                    if (phase_last) begin
                        cnt    <= '0;
                        addr_q <= {word, 1'b1};
                        dq_q   <= data[31:16];
                        state  <= HI;
                        if (!is_write) begin
                            result_q[15:0] <= bus.sram_dq_in;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HI: begin
                    if (phase_last) begin
                        cnt    <= '0;
                        we_n_q <= 1'b1;
                        state  <= DONE;
                        if (!is_write) begin
                            result_q[31:16] <= bus.sram_dq_in;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Directed bench for mem_stage. Two instances: u0 with WAIT_CYCLES=1 and u1
// with WAIT_CYCLES=0, each attached to a small SRAM model. Inputs change 1ns
// after the rising edge, outputs are sampled 3ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_stage_if if0();
    mem_stage_if if1();

    mem_stage #(.BASE_ADDR(1024), .WAIT_CYCLES(1)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    mem_stage #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: half-words 0 and 1 are preset to 0x1234 / 0xABCD, the rest
    // behave as writable storage.
    logic [15:0] sram0 [0:63];
    logic [15:0] sram1 [0:63];

    assign if0.sram_dq_in = (if0.sram_addr == 18'd0) ? 16'h1234 :
                            (if0.sram_addr == 18'd1) ? 16'hABCD :
                            sram0[if0.sram_addr[5:0]];
    assign if1.sram_dq_in = (if1.sram_addr == 18'd0) ? 16'h1234 :
                            (if1.sram_addr == 18'd1) ? 16'hABCD :
                            sram1[if1.sram_addr[5:0]];

    always @(posedge clk) begin
        if (!if0.sram_we_n) sram0[if0.sram_addr[5:0]] <= if0.sram_dq_out;
        if (!if1.sram_we_n) sram1[if1.sram_addr[5:0]] <= if1.sram_dq_out;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if0.mem_read_in = 0; if0.mem_write_in = 0; if0.alu_res_in = 0; if0.val_rm_in = 0;
        if1.mem_read_in = 0; if1.mem_write_in = 0; if1.alu_res_in = 0; if1.val_rm_in = 0;
        next_cycle();
        next_cycle();
        #2;
        checks++; if (if0.ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready0 got=%b exp=1", if0.ready); end
        checks++; if (if0.sram_we_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_we_n0 got=%b exp=1", if0.sram_we_n); end
        checks++; if (if0.sram_addr !== 18'd0) begin failures++; $display("[TB] FAIL reset_addr0 got=%h exp=0", if0.sram_addr); end
        checks++; if (if0.sram_dq_out !== 16'd0) begin failures++; $display("[TB] FAIL reset_dq0 got=%h exp=0", if0.sram_dq_out); end
        checks++; if (if0.mem_result !== 32'd0) begin failures++; $display("[TB] FAIL reset_result0 got=%h exp=0", if0.mem_result); end
        checks++; if (if1.ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready1 got=%b exp=1", if1.ready); end
        checks++; if (if1.sram_we_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_we_n1 got=%b exp=1", if1.sram_we_n); end
        checks++; if (if1.mem_result !== 32'd0) begin failures++; $display("[TB] FAIL reset_result1 got=%h exp=0", if1.mem_result); end
        rst = 1'b0;
        next_cycle();
    endtask

    // Load of half-words 0/1 -> 0xABCD1234 in the DONE cycle (cycle 5).
    task automatic test_read();
        logic        exp_ready [0:6];
        logic [17:0] exp_addr  [0:6];
        exp_ready = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_addr  = '{18'd0, 18'd0, 18'd0, 18'd1, 18'd1, 18'd1, 18'd1};
        if0.alu_res_in = 32'd1024; if0.mem_read_in = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) if0.mem_read_in = 1'b0;
            #2;
            checks++; if (if0.ready !== exp_ready[c]) begin failures++; $display("[TB] FAIL read_ready cyc=%0d got=%b exp=%b", c, if0.ready, exp_ready[c]); end
            checks++; if (if0.sram_we_n !== 1'b1) begin failures++; $display("[TB] FAIL read_we_n cyc=%0d got=%b exp=1", c, if0.sram_we_n); end
            if (c >= 1) begin
                checks++; if (if0.sram_addr !== exp_addr[c]) begin failures++; $display("[TB] FAIL read_addr cyc=%0d got=%h exp=%h", c, if0.sram_addr, exp_addr[c]); end
            end
            if (c >= 5) begin
                checks++; if (if0.mem_result !== 32'hABCD1234) begin failures++; $display("[TB] FAIL read_result cyc=%0d got=%h exp=abcd1234", c, if0.mem_result); end
            end
            next_cycle();
        end
    endtask

    // Store 0xDEADBEEF at byte 1028 -> half-words 2 (BEEF) and 3 (DEAD).
    task automatic test_write();
        logic        exp_ready [0:6];
        logic        exp_we_n  [0:6];
        logic [17:0] exp_addr  [0:6];
        logic [15:0] exp_dq    [0:6];
        exp_ready = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_we_n  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_addr  = '{18'd1, 18'd2, 18'd2, 18'd3, 18'd3, 18'd3, 18'd3};
        exp_dq    = '{16'h0, 16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD};
        if0.alu_res_in = 32'd1028; if0.val_rm_in = 32'hDEADBEEF; if0.mem_write_in = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) if0.mem_write_in = 1'b0;
            #2;
            checks++; if (if0.ready !== exp_ready[c]) begin failures++; $display("[TB] FAIL write_ready cyc=%0d got=%b exp=%b", c, if0.ready, exp_ready[c]); end
            checks++; if (if0.sram_we_n !== exp_we_n[c]) begin failures++; $display("[TB] FAIL write_we_n cyc=%0d got=%b exp=%b", c, if0.sram_we_n, exp_we_n[c]); end
            if (c >= 1) begin
                checks++; if (if0.sram_addr !== exp_addr[c]) begin failures++; $display("[TB] FAIL write_addr cyc=%0d got=%h exp=%h", c, if0.sram_addr, exp_addr[c]); end
                checks++; if (if0.sram_dq_out !== exp_dq[c]) begin failures++; $display("[TB] FAIL write_dq cyc=%0d got=%h exp=%h", c, if0.sram_dq_out, exp_dq[c]); end
            end
            checks++; if (if0.mem_result !== 32'hABCD1234) begin failures++; $display("[TB] FAIL write_result_hold cyc=%0d got=%h exp=abcd1234", c, if0.mem_result); end
            next_cycle();
        end
    endtask

    // Read and write together behave as a store of 0x00000005 to half-words 4/5.
    task automatic test_read_write_both();
        logic        exp_we_n [0:6];
        logic [17:0] exp_addr [0:6];
        logic [15:0] exp_dq   [0:6];
        exp_we_n = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_addr = '{18'd3, 18'd4, 18'd4, 18'd5, 18'd5, 18'd5, 18'd5};
        exp_dq   = '{16'hDEAD, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        if0.alu_res_in = 32'd1032; if0.val_rm_in = 32'h00000005;
        if0.mem_read_in = 1'b1; if0.mem_write_in = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) begin if0.mem_read_in = 1'b0; if0.mem_write_in = 1'b0; end
            #2;
            checks++; if (if0.sram_we_n !== exp_we_n[c]) begin failures++; $display("[TB] FAIL both_we_n cyc=%0d got=%b exp=%b", c, if0.sram_we_n, exp_we_n[c]); end
            checks++; if (if0.sram_addr !== exp_addr[c]) begin failures++; $display("[TB] FAIL both_addr cyc=%0d got=%h exp=%h", c, if0.sram_addr, exp_addr[c]); end
            checks++; if (if0.sram_dq_out !== exp_dq[c]) begin failures++; $display("[TB] FAIL both_dq cyc=%0d got=%h exp=%h", c, if0.sram_dq_out, exp_dq[c]); end
            checks++; if (if0.mem_result !== 32'hABCD1234) begin failures++; $display("[TB] FAIL both_result_hold cyc=%0d got=%h exp=abcd1234", c, if0.mem_result); end
            next_cycle();
        end
    endtask

    // Two loads; the second is already presented in the DONE cycle of the first.
    task automatic test_back_to_back();
        logic        exp_ready [0:12];
        logic [17:0] exp_addr  [0:12];
        exp_ready = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_addr  = '{18'd5, 18'd2, 18'd2, 18'd3, 18'd3, 18'd3,
                      18'd3, 18'd4, 18'd4, 18'd5, 18'd5, 18'd5, 18'd5};
        if0.alu_res_in = 32'd1028; if0.mem_read_in = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (c == 5)  if0.alu_res_in = 32'd1032;
            if (c == 11) if0.mem_read_in = 1'b0;
            #2;
            checks++; if (if0.ready !== exp_ready[c]) begin failures++; $display("[TB] FAIL b2b_ready cyc=%0d got=%b exp=%b", c, if0.ready, exp_ready[c]); end
            checks++; if (if0.sram_addr !== exp_addr[c]) begin failures++; $display("[TB] FAIL b2b_addr cyc=%0d got=%h exp=%h", c, if0.sram_addr, exp_addr[c]); end
            checks++; if (if0.sram_we_n !== 1'b1) begin failures++; $display("[TB] FAIL b2b_we_n cyc=%0d got=%b exp=1", c, if0.sram_we_n); end
            if (c == 5) begin
                checks++; if (if0.mem_result !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL b2b_result1 got=%h exp=deadbeef", if0.mem_result); end
            end
            if (c >= 11) begin
                checks++; if (if0.mem_result !== 32'h00000005) begin failures++; $display("[TB] FAIL b2b_result2 cyc=%0d got=%h exp=00000005", c, if0.mem_result); end
            end
            next_cycle();
        end
    endtask

    // Reset in the second HI cycle of a store aborts it completely.
    task automatic test_reset_mid_access();
        if0.alu_res_in = 32'd1036; if0.val_rm_in = 32'h11112222; if0.mem_write_in = 1'b1;
        for (int c = 0; c < 4; c++) next_cycle();
        #2;
        checks++; if (if0.sram_we_n !== 1'b0) begin failures++; $display("[TB] FAIL mid_pre_we_n got=%b exp=0", if0.sram_we_n); end
        checks++; if (if0.sram_addr !== 18'd7) begin failures++; $display("[TB] FAIL mid_pre_addr got=%h exp=7", if0.sram_addr); end
        rst = 1'b1;
        if0.mem_write_in = 1'b0;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #2;
            checks++; if (if0.sram_we_n !== 1'b1) begin failures++; $display("[TB] FAIL mid_we_n cyc=%0d got=%b exp=1", c, if0.sram_we_n); end
            checks++; if (if0.ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_ready cyc=%0d got=%b exp=1", c, if0.ready); end
            checks++; if (if0.sram_addr !== 18'd0) begin failures++; $display("[TB] FAIL mid_addr cyc=%0d got=%h exp=0", c, if0.sram_addr); end
            checks++; if (if0.sram_dq_out !== 16'd0) begin failures++; $display("[TB] FAIL mid_dq cyc=%0d got=%h exp=0", c, if0.sram_dq_out); end
            checks++; if (if0.mem_result !== 32'd0) begin failures++; $display("[TB] FAIL mid_result cyc=%0d got=%h exp=0", c, if0.mem_result); end
            next_cycle();
        end
    endtask

    // Ten non-memory instructions: no stall, SRAM pins untouched.
    task automatic test_no_mem();
        for (int c = 0; c < 10; c++) begin
            if0.alu_res_in = 32'd1024 + 32'(c * 4);
            if0.val_rm_in  = $urandom;
            #2;
            checks++; if (if0.ready !== 1'b1) begin failures++; $display("[TB] FAIL nomem_ready cyc=%0d got=%b exp=1", c, if0.ready); end
            checks++; if (if0.sram_we_n !== 1'b1) begin failures++; $display("[TB] FAIL nomem_we_n cyc=%0d got=%b exp=1", c, if0.sram_we_n); end
            checks++; if (if0.sram_addr !== 18'd0) begin failures++; $display("[TB] FAIL nomem_addr cyc=%0d got=%h exp=0", c, if0.sram_addr); end
            checks++; if (if0.sram_dq_out !== 16'd0) begin failures++; $display("[TB] FAIL nomem_dq cyc=%0d got=%h exp=0", c, if0.sram_dq_out); end
            next_cycle();
        end
    endtask

    // WAIT_CYCLES=0 instance: one cycle per half-word, three-cycle freeze.
    task automatic test_wait0();
        logic        exp_ready [0:4];
        logic        exp_we_n  [0:4];
        logic [17:0] exp_addr  [0:4];
        logic [15:0] exp_dq    [0:4];
        exp_ready = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_we_n  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_addr  = '{18'd0, 18'd2, 18'd3, 18'd3, 18'd3};
        exp_dq    = '{16'h0, 16'hF00D, 16'hCAFE, 16'hCAFE, 16'hCAFE};
        if1.alu_res_in = 32'd1028; if1.val_rm_in = 32'hCAFEF00D; if1.mem_write_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) if1.mem_write_in = 1'b0;
            #2;
            checks++; if (if1.ready !== exp_ready[c]) begin failures++; $display("[TB] FAIL w0_wr_ready cyc=%0d got=%b exp=%b", c, if1.ready, exp_ready[c]); end
            checks++; if (if1.sram_we_n !== exp_we_n[c]) begin failures++; $display("[TB] FAIL w0_wr_we_n cyc=%0d got=%b exp=%b", c, if1.sram_we_n, exp_we_n[c]); end
            checks++; if (if1.sram_addr !== exp_addr[c]) begin failures++; $display("[TB] FAIL w0_wr_addr cyc=%0d got=%h exp=%h", c, if1.sram_addr, exp_addr[c]); end
            checks++; if (if1.sram_dq_out !== exp_dq[c]) begin failures++; $display("[TB] FAIL w0_wr_dq cyc=%0d got=%h exp=%h", c, if1.sram_dq_out, exp_dq[c]); end
            next_cycle();
        end
        if1.mem_read_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 3) if1.mem_read_in = 1'b0;
            #2;
            checks++; if (if1.ready !== exp_ready[c]) begin failures++; $display("[TB] FAIL w0_rd_ready cyc=%0d got=%b exp=%b", c, if1.ready, exp_ready[c]); end
            checks++; if (if1.sram_we_n !== 1'b1) begin failures++; $display("[TB] FAIL w0_rd_we_n cyc=%0d got=%b exp=1", c, if1.sram_we_n); end
            if (c >= 3) begin
                checks++; if (if1.mem_result !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL w0_rd_result cyc=%0d got=%h exp=cafef00d", c, if1.mem_result); end
            end
            next_cycle();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        #1;
        test_reset();
        test_read();
        test_write();
        test_read_write_both();
        test_back_to_back();
        test_reset_mid_access();
        test_no_mem();
        test_wait0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
